// File: rtl/note_tone_generator.sv
// Square-wave tone generator: plays one note from a fixed C4..C5 pitch table for a set
// duration, then holds a silent gap before it accepts the next note.
module note_tone_generator #(
    parameter int CLK_HZ      = 50000000,
    parameter int DIV_SHIFT   = 0,
    parameter int NOTE_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [2:0] note_idx,
    input  logic       stop,
    output logic       note_ready,
    output logic       playing,
    output logic [2:0] cur_note,
    output logic       audio_out
);

    // The pitch table is tuned for a 50 MHz clock; reject nonsensical settings at elaboration.
    if (CLK_HZ != 50000000 || NOTE_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
        $error("note_tone_generator: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

    function automatic logic [16:0] half_period(input logic [2:0] idx);
        logic [16:0] base;
        logic [16:0] shifted;
        case (idx)
            3'd0:    base = 17'd95555;
            3'd1:    base = 17'd85132;
            3'd2:    base = 17'd75843;
            3'd3:    base = 17'd71586;
            3'd4:    base = 17'd63776;
            3'd5:    base = 17'd56818;
            3'd6:    base = 17'd50620;
            default: base = 17'd47778;
        endcase
        shifted = base >> DIV_SHIFT;
        return (shifted == 17'd0) ? 17'd1 : shifted;
    endfunction

    state_t      state_q,    state_d;
    logic [2:0]  cur_note_q, cur_note_d;
    logic [16:0] hp_q,       hp_d;
    logic [16:0] tone_cnt_q, tone_cnt_d;
    logic [31:0] dur_cnt_q,  dur_cnt_d;
    logic        audio_q,    audio_d;

    always_comb begin
        state_d    = state_q;
        cur_note_d = cur_note_q;
        hp_d       = hp_q;
        tone_cnt_d = tone_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        audio_d    = audio_q;
        case (state_q)
            IDLE: begin
                audio_d = 1'b0;
                if (note_valid && !stop) begin
                    state_d    = PLAY;
                    cur_note_d = note_idx;
                    hp_d       = half_period(note_idx);
                    tone_cnt_d = 17'd0;
                    dur_cnt_d  = 32'd0;
                    audio_d    = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d    = IDLE;
                    tone_cnt_d = 17'd0;
                    dur_cnt_d  = 32'd0;
                    audio_d    = 1'b0;
                end else if (dur_cnt_q == NOTE_LAST) begin
                    // End of the note beats a coincident toggle, so the gap always starts low.
                    state_d    = GAP;
                    tone_cnt_d = 17'd0;
                    dur_cnt_d  = 32'd0;
                    audio_d    = 1'b0;
                end else begin
                    dur_cnt_d = dur_cnt_q + 32'd1;
                    if (tone_cnt_q == hp_q - 17'd1) begin
                        tone_cnt_d = 17'd0;
                        audio_d    = ~audio_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 17'd1;
                    end
                end
            end
            GAP: begin
                audio_d = 1'b0;
                if (stop || dur_cnt_q == GAP_LAST) begin
                    state_d    = IDLE;
                    tone_cnt_d = 17'd0;
                    dur_cnt_d  = 32'd0;
                end else begin
                    dur_cnt_d = dur_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                tone_cnt_d = 17'd0;
                dur_cnt_d  = 32'd0;
                audio_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_note_q <= 3'd0;
            hp_q       <= 17'd0;
            tone_cnt_q <= 17'd0;
            dur_cnt_q  <= 32'd0;
            audio_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_note_q <= cur_note_d;
            hp_q       <= hp_d;
            tone_cnt_q <= tone_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            audio_q    <= audio_d;
        end
    end

    assign note_ready = (state_q == IDLE);
    assign playing    = (state_q == PLAY);
    assign cur_note   = cur_note_q;
    assign audio_out  = audio_q;

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: directed scenarios followed by random traffic, all
// checked every cycle against a time-since-accept reference model.
module tb_note_tone_generator;

    localparam int DIV_SHIFT   = 10;
    localparam int NOTE_CYCLES = 1000;
    localparam int GAP_CYCLES  = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       note_valid;
    logic [2:0] note_idx;
    logic       stop;
    logic       note_ready;
    logic       playing;
    logic [2:0] cur_note;
    logic       audio_out;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: phase 0 = waiting, 1 = sounding, 2 = silent gap.
    int         m_phase   = 0;
    int         m_elapsed = 0;
    int         m_hp      = 1;
    logic [2:0] m_cur     = 3'd0;
    int         base_table[8] = '{95555, 85132, 75843, 71586, 63776, 56818, 50620, 47778};

    note_tone_generator #(
        .CLK_HZ     (50000000),
        .DIV_SHIFT  (DIV_SHIFT),
        .NOTE_CYCLES(NOTE_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .note_valid(note_valid),
        .note_idx  (note_idx),
        .stop      (stop),
        .note_ready(note_ready),
        .playing   (playing),
        .cur_note  (cur_note),
        .audio_out (audio_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic int model_hp(input logic [2:0] idx);
        int hp;
        hp = base_table[idx] >> DIV_SHIFT;
        return (hp == 0) ? 1 : hp;
    endfunction

    // The tone is high for the first HP cycles after an accept, then alternates every HP cycles.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [2:0] idx, input logic stp);
        logic exp_audio;
        reset      = rst;
        note_valid = valid;
        note_idx   = idx;
        stop       = stp;
        @(posedge clk);
        if (rst) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_cur     = 3'd0;
        end else if (m_phase == 0) begin
            if (valid && !stp) begin
                m_phase   = 1;
                m_elapsed = 0;
                m_cur     = idx;
                m_hp      = model_hp(idx);
            end
        end else if (stp) begin
            m_phase   = 0;
            m_elapsed = 0;
        end else begin
            m_elapsed++;
            if (m_phase == 1 && m_elapsed == NOTE_CYCLES) begin
                m_phase   = 2;
                m_elapsed = 0;
            end else if (m_phase == 2 && m_elapsed == GAP_CYCLES) begin
                m_phase   = 0;
                m_elapsed = 0;
            end
        end
        exp_audio = (m_phase == 1) && (((m_elapsed / m_hp) % 2) == 0);
        @(negedge clk);
        checkOutput("note_ready", 32'(note_ready), 32'(m_phase == 0));
        checkOutput("playing",    32'(playing),    32'(m_phase == 1));
        checkOutput("cur_note",   32'(cur_note),   32'(m_cur));
        checkOutput("audio_out",  32'(audio_out),  32'(exp_audio));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        note_valid = 1'b0;
        note_idx   = 3'd0;
        stop       = 1'b0;

        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0);
        idleCycles(3);

        // Full C4 note, then full C5 note, each with the complete gap.
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
        idleCycles(NOTE_CYCLES + GAP_CYCLES + 10);
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b0);
        idleCycles(NOTE_CYCLES + GAP_CYCLES + 10);

        // A request during a note must not retune or restart it.
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0);
        idleCycles(200);
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0);
        idleCycles(NOTE_CYCLES + GAP_CYCLES);

        // Abort mid-note, then a normal accept.
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b0);
        idleCycles(299);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0);
        idleCycles(NOTE_CYCLES + GAP_CYCLES + 5);

        // Stop and request together while waiting: no accept.
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b1);
        idleCycles(3);

        // Reset in the middle of the gap.
        applyStimulus(1'b0, 1'b1, 3'd6, 1'b0);
        idleCycles(NOTE_CYCLES + 20);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        idleCycles(5);

        // Random traffic: frequent requests, occasional stops and resets.
        for (int i = 0; i < 20000; i++) begin
            applyStimulus(($urandom_range(0, 4999) == 0),
                          ($urandom_range(0, 7) == 0),
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 1499) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/note_tone_generator.md
Name: note_tone_generator

Overview:
- Consumes the 3-bit note index from the one-hot-to-binary key encoder, plus a load strobe, and produces a square-wave audio output at the matching pitch.
- Pitches run from C4 (index 0) to C5 (index 7).
- Each accepted note plays for a fixed duration, then holds a fixed silent articulation gap, then returns idle.
- Sits between the key encoder and the audio output pin/PWM stage.

Parameters:
- CLK_HZ, 50000000, system clock frequency; documents the base half-period table below, which is fixed for 50 MHz.
- DIV_SHIFT, 0, right-shift applied to every half-period table entry; used for simulation speed-up.
- NOTE_CYCLES, 25000000, number of clock cycles a note sounds; minimum 1.
- GAP_CYCLES, 2500000, number of silent clock cycles after each note; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- note_valid  input  1  request to play note_idx; accepted only when note_ready=1.
- note_idx  input  3  binary note index from the encoder.
- stop  input  1  abort the current note or gap; return to IDLE.
- note_ready  output  1  high only in IDLE.
- playing  output  1  high only in PLAY.
- cur_note  output  3  index latched at the last accept.
- audio_out  output  1  square-wave tone; 0 whenever not in PLAY.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE.
  - audio_out=0, playing=0, note_ready=1, cur_note=0.
  - All counters cleared to 0.
- Base half-period table, in clk cycles:
  - 0=95555, 1=85132, 2=75843, 3=71586
  - 4=63776, 5=56818, 6=50620, 7=47778
- Effective half-period: HP = base >> DIV_SHIFT. If HP=0, use HP=1. Tone counter is 17 bits wide.
- State IDLE:
  - note_ready=1.
  - Accept occurs on a cycle with note_valid=1 and stop=0.
  - On accept: cur_note<=note_idx, HP latched, tone_cnt<=0, dur_cnt<=0, state<=PLAY, audio_out<=1.
  - The tone therefore starts high on the first PLAY cycle; latency from accept edge to audio_out=1 is 1 cycle.
- State PLAY:
  - Each cycle, tone_cnt increments.
  - When tone_cnt=HP-1: audio_out toggles and tone_cnt<=0. Each level therefore lasts exactly HP cycles, giving period 2*HP.
  - dur_cnt increments each cycle.
  - When dur_cnt=NOTE_CYCLES-1: state<=GAP, audio_out<=0, dur_cnt<=0. PLAY lasts exactly NOTE_CYCLES cycles.
  - If the toggle point and end of duration coincide, the end of duration wins and audio_out=0.
- State GAP:
  - audio_out=0.
  - dur_cnt counts up to GAP_CYCLES-1, then state<=IDLE.
- note_valid outside IDLE is ignored: no latch, no restart, no queuing. cur_note holds its value.
- stop=1 in PLAY or GAP: next cycle state=IDLE, audio_out=0, counters cleared, cur_note held.
- stop=1 in IDLE together with note_valid=1: stop wins and no accept occurs.
- Outputs note_ready and playing are decoded from registered state. They change on the same edge as the state.
- note_idx is sampled only at accept. Changes during PLAY do not alter pitch.
- Duration and gap counters are 32 bits wide.

Test Plan:
- Reset then idle, DIV_SHIFT=10, NOTE_CYCLES=1000, GAP_CYCLES=50 -> note_ready=1, audio_out=0, cur_note=0.
- Accept C4: note_valid=1, note_idx=0 for 1 cycle (HP=93) -> next cycle playing=1, note_ready=0, audio_out=1. Output toggles every 93 cycles. At cycle 1000 of PLAY, audio_out=0 and state=GAP. After 50 cycles note_ready=1.
- Accept C5: note_idx=7 (HP=46) -> levels last 46 cycles, period 92. cur_note=7.
- Retrigger ignored: during PLAY of note 2, pulse note_valid with note_idx=5 -> cur_note stays 2, toggle spacing stays 74 cycles, duration unchanged.
- Stop mid-note: stop=1 at PLAY cycle 300 -> next cycle audio_out=0, note_ready=1, playing=0, with no GAP. A subsequent note_valid is accepted normally.
- Simultaneous events and reset:
  - In IDLE, stop=1 and note_valid=1 on the same cycle -> no accept.
  - Assert reset mid-GAP -> next cycle all outputs are at reset values and cur_note=0.
